example_dut: RTL and testbench



---
 rtl/example_dut_pkg.sv | 31 +++
 rtl/example_dut_seg7_hex.sv | 32 +++
 rtl/example_dut.sv | 147 ++++++++++++++
 tb/tb_example_dut.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/example_dut_pkg.sv
// Shared constants for example_dut: seven-segment glyphs, key indices, counter width.
package example_dut_pkg;

  localparam int COUNT_W = 24;

  typedef logic [COUNT_W-1:0] count_t;

  localparam int KEY_CLR  = 0;
  localparam int KEY_STEP = 1;
  localparam int KEY_LOAD = 2;
  localparam int KEY_RUN  = 3;

  // Active-low segments, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/example_dut_seg7_hex.sv
// Hex nibble to active-low seven-segment glyph decoder.
module seg7_hex
  import example_dut_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_0;
    case (i_nib)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/example_dut.sv
// Board demo: 24-bit up/down counter with prescaled run, step, clear and byte load, shown on six HEX digits.
// Optional key debounce after the synchronizer is compiled in with EXAMPLE_DUT_DEBOUNCE_EN.
module example_dut
  import example_dut_pkg::*;
#(
  parameter int DIV             = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_sw,
  input  logic [3:0] i_key,
  output logic [9:0] o_led,
  output logic [6:0] o_hex0,
  output logic [6:0] o_hex1,
  output logic [6:0] o_hex2,
  output logic [6:0] o_hex3,
  output logic [6:0] o_hex4,
  output logic [6:0] o_hex5
);

  localparam int              PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  if (DIV < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("example_dut: DIV and DEBOUNCE_CYCLES must be >= 1");
  end

  logic [3:0] r_key_s1;
  logic [3:0] r_key_s2;
  logic [3:0] w_key_st;
  logic [3:0] r_key_prev;
  logic [3:0] w_press;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_key_s1 <= 4'hF;
      r_key_s2 <= 4'hF;
    end else begin
      r_key_s1 <= i_key;
      r_key_s2 <= r_key_s1;
    end
  end

`ifdef EXAMPLE_DUT_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [3:0]      r_db_state;
  logic [DB_W-1:0] r_db_cnt [4];

  // A key's state follows the synchronized input only after DEBOUNCE_CYCLES
  // consecutive samples that disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_db_state <= 4'hF;
      for (int k = 0; k < 4; k++) r_db_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (r_key_s2[k] == r_db_state[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_db_state[k] <= r_key_s2[k];
          r_db_cnt[k]   <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign w_key_st = r_db_state;
`else
  assign w_key_st = r_key_s2;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_key_prev <= 4'hF;
    else       r_key_prev <= w_key_st;
  end

  // Keys are active-low, so a press is a 1->0 transition of the settled state.
  assign w_press = r_key_prev & ~w_key_st;

  logic       w_clr;
  logic       w_load;
  logic       w_step;
  logic       w_run_tgl;
  logic       w_tick;

  assign w_clr     = ~w_key_st[KEY_CLR];
  assign w_load    = w_press[KEY_LOAD];
  assign w_step    = w_press[KEY_STEP];
  assign w_run_tgl = w_press[KEY_RUN];

  count_t           r_count;
  count_t           w_count_nxt;
  count_t           r_disp;
  logic [PRE_W-1:0] r_pre;
  logic [PRE_W-1:0] w_pre_nxt;
  logic             r_run;
  logic             r_dir;

  assign w_tick = r_run && (r_pre == PRE_MAX);

  always_comb begin
    w_pre_nxt   = r_pre;
    w_count_nxt = r_count;

    if (w_clr || !r_run || w_tick) w_pre_nxt = '0;
    else                           w_pre_nxt = r_pre + 1'b1;

    // Single count update per cycle: clear > load > step > tick.
    if (w_clr) begin
      w_count_nxt = '0;
    end else if (w_load) begin
      w_count_nxt = {r_count[COUNT_W-1:8], i_sw[9:2]};
    end else if (w_step || w_tick) begin
      w_count_nxt = r_dir ? (r_count - 1'b1) : (r_count + 1'b1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_pre   <= '0;
      r_run   <= 1'b0;
      r_dir   <= 1'b0;
      r_disp  <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_pre   <= w_pre_nxt;
      r_dir   <= i_sw[1];
      if (w_run_tgl) r_run  <= ~r_run;
      if (!i_sw[0])  r_disp <= r_count;
    end
  end

  assign o_led = {r_run, r_dir, r_count[7:0]};

  seg7_hex u_hex0 (.i_nib(r_disp[3:0]),   .o_seg(o_hex0));
  seg7_hex u_hex1 (.i_nib(r_disp[7:4]),   .o_seg(o_hex1));
  seg7_hex u_hex2 (.i_nib(r_disp[11:8]),  .o_seg(o_hex2));
  seg7_hex u_hex3 (.i_nib(r_disp[15:12]), .o_seg(o_hex3));
  seg7_hex u_hex4 (.i_nib(r_disp[19:16]), .o_seg(o_hex4));
  seg7_hex u_hex5 (.i_nib(r_disp[23:20]), .o_seg(o_hex5));

endmodule

// File: tb/tb_example_dut.sv
// Directed bench for example_dut: stepping/loading/clearing table plus run, freeze and reset sequences.
module tb_example_dut;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] sw;
  logic [3:0] key;
  logic [9:0] led;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] GF = 7'b0001110;

  example_dut #(.DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_sw  (sw),
    .i_key (key),
    .o_led (led),
    .o_hex0(hex0),
    .o_hex1(hex1),
    .o_hex2(hex2),
    .o_hex3(hex3),
    .o_hex4(hex4),
    .o_hex5(hex5)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [9:0] sw;
    logic [3:0] key;
    logic [9:0] led;
    logic [6:0] h0;
    logic [6:0] h5;
  } vec_t;

  vec_t tbl [21];

  initial begin
    // Run stays 0 throughout; each row is held for 4 edges (2 sync + action + display).
    tbl[0]  = '{10'h000, 4'hF, 10'h000, G0, G0};
    tbl[1]  = '{10'h000, 4'hD, 10'h001, G1, G0};
    tbl[2]  = '{10'h000, 4'hF, 10'h001, G1, G0};
    tbl[3]  = '{10'h000, 4'hD, 10'h002, G2, G0};
    tbl[4]  = '{10'h002, 4'hF, 10'h102, G2, G0};
    tbl[5]  = '{10'h002, 4'hD, 10'h101, G1, G0};
    tbl[6]  = '{10'h002, 4'hF, 10'h101, G1, G0};
    tbl[7]  = '{10'h002, 4'hD, 10'h100, G0, G0};
    tbl[8]  = '{10'h002, 4'hF, 10'h100, G0, G0};
    tbl[9]  = '{10'h002, 4'hD, 10'h1FF, GF, GF};
    tbl[10] = '{10'h002, 4'hF, 10'h1FF, GF, GF};
    tbl[11] = '{10'h296, 4'hB, 10'h1A5, G5, GF};
    tbl[12] = '{10'h296, 4'hF, 10'h1A5, G5, GF};
    tbl[13] = '{10'h3FC, 4'hB, 10'h0FF, GF, GF};
    tbl[14] = '{10'h3FC, 4'hF, 10'h0FF, GF, GF};
    tbl[15] = '{10'h3FC, 4'hD, 10'h000, G0, G0};
    tbl[16] = '{10'h3FC, 4'hF, 10'h000, G0, G0};
    tbl[17] = '{10'h294, 4'hB, 10'h0A5, G5, G0};
    tbl[18] = '{10'h294, 4'hF, 10'h0A5, G5, G0};
    tbl[19] = '{10'h294, 4'hE, 10'h000, G0, G0};
    tbl[20] = '{10'h000, 4'hF, 10'h000, G0, G0};

    rst = 1'b1;
    sw  = 10'h000;
    key = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_led",  32'(led),  32'h000);
    chk("rst_hex0", 32'(hex0), 32'(G0));
    chk("rst_hex1", 32'(hex1), 32'(G0));
    chk("rst_hex2", 32'(hex2), 32'(G0));
    chk("rst_hex3", 32'(hex3), 32'(G0));
    chk("rst_hex4", 32'(hex4), 32'(G0));
    chk("rst_hex5", 32'(hex5), 32'(G0));
    rst = 1'b0;
    tick(100);
    chk("idle_led",  32'(led),  32'h000);
    chk("idle_hex0", 32'(hex0), 32'(G0));
    chk("idle_hex5", 32'(hex5), 32'(G0));

    for (int i = 0; i < 21; i++) begin
      sw  = tbl[i].sw;
      key = tbl[i].key;
      tick(4);
      chk($sformatf("tbl%0d_led", i),  32'(led),  32'(tbl[i].led));
      chk($sformatf("tbl%0d_hex0", i), 32'(hex0), 32'(tbl[i].h0));
      chk($sformatf("tbl%0d_hex5", i), 32'(hex5), 32'(tbl[i].h5));
    end

    // Run toggle: first tick lands 4 edges after run sets, then every 4.
    key = 4'b0111;
    tick(3);
    chk("run_on",    32'(led), 32'h200);
    key = 4'hF;
    tick(3);
    chk("run_pre",   32'(led), 32'h200);
    tick(1);
    chk("run_cnt1",  32'(led), 32'h201);
    tick(1);
    chk("run_hex1",  32'(hex0), 32'(G1));
    tick(3);
    chk("run_cnt2",  32'(led), 32'h202);
    tick(4);
    chk("run_cnt3",  32'(led), 32'h203);

    // Clear held together with a step press: clear wins and holds.
    key = 4'b1100;
    tick(3);
    chk("clr_win",   32'(led), 32'h200);
    tick(10);
    chk("clr_hold",  32'(led), 32'h200);
    key = 4'hF;
    tick(5);
    chk("clr_rel",   32'(led), 32'h200);
    tick(1);
    chk("clr_resume", 32'(led), 32'h201);

    // Display freeze.
    tick(1);
    chk("frz_pre_hex", 32'(hex0), 32'(G1));
    sw = 10'h001;
    tick(4);
    chk("frz_led2",  32'(led),  32'h202);
    chk("frz_hex2",  32'(hex0), 32'(G1));
    tick(4);
    chk("frz_led3",  32'(led),  32'h203);
    chk("frz_hex3",  32'(hex0), 32'(G1));
    sw = 10'h000;
    tick(1);
    chk("frz_catchup", 32'(hex0), 32'(G3));

    // Run off: a tick still lands on the edge before the toggle takes effect.
    key = 4'b0111;
    tick(3);
    chk("run_off",   32'(led), 32'h004);
    key = 4'hF;
    tick(8);
    chk("stopped",   32'(led), 32'h004);
    chk("stop_hex",  32'(hex0), 32'(G4));

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    chk("arst_led",  32'(led),  32'h000);
    chk("arst_hex0", 32'(hex0), 32'(G0));
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    chk("post_rst",  32'(led), 32'h000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
